// File: rtl/bshift_pkg.sv
// Shared types and helpers for the pipelined barrel shifter / rotator.
// The package works on a 64-bit container (the widest supported WIDTH);
// callers zero-extend their operand and truncate the result.
package bshift_pkg;

    localparam int BSHIFT_OP_W  = 3;
    localparam int BSHIFT_MAX_W = 64;

    typedef enum logic [BSHIFT_OP_W-1:0] {
        OP_PASS = 3'd0,
        OP_SLL  = 3'd1,
        OP_SRL  = 3'd2,
        OP_SRA  = 3'd3,
        OP_ROL  = 3'd4,
        OP_ROR  = 3'd5
    } bshift_op_e;

    // Opcodes 110 and 111 carry no defined operation.
    function automatic logic bshift_op_undef(input logic [BSHIFT_OP_W-1:0] op);
        return (op > 3'd5);
    endfunction

    // Single bit of a container, selected by shifting so any int index works.
    function automatic logic bshift_bit_at(input logic [BSHIFT_MAX_W-1:0] d, input int idx);
        return (((d >> idx) & 64'd1) != 64'd0);
    endfunction

    // Apply one mux level: shift/rotate by 2^k within a WIDTH-bit operand.
    // Undefined opcodes and PASS leave the operand untouched.
    function automatic logic [BSHIFT_MAX_W-1:0] bshift_level(
        input logic [BSHIFT_MAX_W-1:0] d,
        input int                      width,
        input logic [BSHIFT_OP_W-1:0]  op,
        input int                      k
    );
        logic [BSHIFT_MAX_W-1:0] mask_w;
        logic [BSHIFT_MAX_W-1:0] fill;
        logic [BSHIFT_MAX_W-1:0] r;
        int                      s;
        s      = 1 << k;
        mask_w = (width >= BSHIFT_MAX_W) ? {BSHIFT_MAX_W{1'b1}}
                                         : ((64'd1 << width) - 64'd1);
        // Top s bits of the operand, used as the sign fill for SRA.
        fill   = mask_w & ~(mask_w >> s);
        case (bshift_op_e'(op))
            OP_SLL:  r = (d << s) & mask_w;
            OP_SRL:  r = d >> s;
            OP_SRA:  r = bshift_bit_at(d, width - 1) ? ((d >> s) | fill) : (d >> s);
            OP_ROL:  r = ((d << s) | (d >> (width - s))) & mask_w;
            OP_ROR:  r = ((d >> s) | (d << (width - s))) & mask_w;
            default: r = d;
        endcase
        return r;
    endfunction

    // Last bit pushed out by this level. Applying this level by level gives
    // the overall last bit shifted out, because each level sees the operand
    // already shifted by the lower amount bits.
    function automatic logic bshift_level_carry(
        input logic [BSHIFT_MAX_W-1:0] d,
        input int                      width,
        input logic [BSHIFT_OP_W-1:0]  op,
        input int                      k,
        input logic                    c_in
    );
        logic c;
        int   s;
        s = 1 << k;
        case (bshift_op_e'(op))
            OP_SLL:          c = bshift_bit_at(d, width - s);
            OP_SRL, OP_SRA:  c = bshift_bit_at(d, s - 1);
            default:         c = c_in;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/bshift_stage.sv
// One register slice of the barrel shifter: applies LEVEL_CNT mux levels
// starting at FIRST_LEVEL and holds the partial result with its remaining
// amount, opcode, error flag and valid bit.
// Optional carry tracking is compiled in with BSHIFT_FLAGS_EN.
module bshift_stage
    import bshift_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int FIRST_LEVEL = 0,
    parameter int LEVEL_CNT   = 1,
    localparam int AW         = $clog2(WIDTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   prev_valid,
    input  logic [WIDTH-1:0]       prev_data,
    input  logic [AW-1:0]          prev_amt,
    input  logic [BSHIFT_OP_W-1:0] prev_op,
    input  logic                   prev_err,
`ifdef BSHIFT_FLAGS_EN
    input  logic                   prev_carry,
    output logic                   carry_q,
`endif
    input  logic                   next_ready,
    output logic                   load_ok,
    output logic                   valid_q,
    output logic [WIDTH-1:0]       data_q,
    output logic [AW-1:0]          amt_q,
    output logic [BSHIFT_OP_W-1:0] op_q,
    output logic                   err_q
);

    logic                   valid_d;
    logic [WIDTH-1:0]       data_d;
    logic [AW-1:0]          amt_d;
    logic [BSHIFT_OP_W-1:0] op_d;
    logic                   err_d;
    logic [WIDTH-1:0]       cur_s;
`ifdef BSHIFT_FLAGS_EN
    logic                   carry_d;
    logic                   cur_carry_s;
`endif

    // Advance decision, this slice's mux levels and next register values.
    always_comb begin
        load_ok = !valid_q || next_ready;
        valid_d = valid_q;
        data_d  = data_q;
        amt_d   = amt_q;
        op_d    = op_q;
        err_d   = err_q;
        cur_s   = prev_data;
`ifdef BSHIFT_FLAGS_EN
        carry_d     = carry_q;
        cur_carry_s = prev_carry;
`endif
        for (int j = 0; j < LEVEL_CNT; j++) begin
            if (((prev_amt >> (FIRST_LEVEL + j)) & AW'(1)) != {AW{1'b0}}) begin
`ifdef BSHIFT_FLAGS_EN
                cur_carry_s = bshift_level_carry(64'(cur_s), WIDTH, prev_op,
                                                 FIRST_LEVEL + j, cur_carry_s);
`endif
                cur_s = WIDTH'(bshift_level(64'(cur_s), WIDTH, prev_op, FIRST_LEVEL + j));
            end else begin
                cur_s = cur_s;
            end
        end
        if (load_ok) begin
            valid_d = prev_valid;
            if (prev_valid) begin
                data_d = cur_s;
                amt_d  = prev_amt;
                op_d   = prev_op;
                err_d  = prev_err;
`ifdef BSHIFT_FLAGS_EN
                carry_d = cur_carry_s;
`endif
            end else begin
                data_d = data_q;
            end
        end else begin
            valid_d = valid_q;
        end
    end

    // Slice registers; cleared asynchronously so in-flight beats vanish.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= {WIDTH{1'b0}};
            amt_q   <= {AW{1'b0}};
            op_q    <= {BSHIFT_OP_W{1'b0}};
            err_q   <= 1'b0;
`ifdef BSHIFT_FLAGS_EN
            carry_q <= 1'b0;
`endif
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            amt_q   <= amt_d;
            op_q    <= op_d;
            err_q   <= err_d;
`ifdef BSHIFT_FLAGS_EN
            carry_q <= carry_d;
`endif
        end
    end

endmodule

// File: rtl/bshift_pipe.sv
// Pipelined barrel shifter / rotator with valid/ready on both sides.
// log2(WIDTH) mux levels are split over PIPE_DEPTH bshift_stage slices,
// ceil(log2(WIDTH)/PIPE_DEPTH) levels each (the last may hold fewer).
// Define BSHIFT_FLAGS_EN to add the out_zero and out_carry outputs.
module bshift_pipe
    import bshift_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int PIPE_DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    input  logic [$clog2(WIDTH)-1:0]   in_amt,
    input  logic [BSHIFT_OP_W-1:0]     in_op,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
`ifdef BSHIFT_FLAGS_EN
    output logic                       out_zero,
    output logic                       out_carry,
`endif
    output logic                       out_op_err
);

    localparam int AW  = $clog2(WIDTH);
    localparam int LPS = (AW + PIPE_DEPTH - 1) / PIPE_DEPTH;

    // Per-stage register outputs and load permissions.
    logic                   valid_s [PIPE_DEPTH];
    logic [WIDTH-1:0]       data_s  [PIPE_DEPTH];
    logic [AW-1:0]          amt_s   [PIPE_DEPTH];
    logic [BSHIFT_OP_W-1:0] op_s    [PIPE_DEPTH];
    logic                   err_s   [PIPE_DEPTH];
    logic                   rdy_s   [PIPE_DEPTH];
`ifdef BSHIFT_FLAGS_EN
    logic                   carry_s [PIPE_DEPTH];
`endif

    for (genvar i = 0; i < PIPE_DEPTH; i++) begin : g_stage
        localparam int FIRST = i * LPS;
        localparam int CNT   = ((AW - FIRST) > LPS) ? LPS
                             : (((AW - FIRST) > 0) ? (AW - FIRST) : 0);

        logic                   pv_s;
        logic [WIDTH-1:0]       pd_s;
        logic [AW-1:0]          pa_s;
        logic [BSHIFT_OP_W-1:0] po_s;
        logic                   pe_s;
        logic                   nr_s;
`ifdef BSHIFT_FLAGS_EN
        logic                   pc_s;
`endif

        if (i == 0) begin : g_head
            assign pv_s = in_valid;
            assign pd_s = in_data;
            assign pa_s = in_amt;
            assign po_s = in_op;
            assign pe_s = bshift_op_undef(in_op);
`ifdef BSHIFT_FLAGS_EN
            assign pc_s = 1'b0;
`endif
        end else begin : g_link
            assign pv_s = valid_s[i-1];
            assign pd_s = data_s[i-1];
            assign pa_s = amt_s[i-1];
            assign po_s = op_s[i-1];
            assign pe_s = err_s[i-1];
`ifdef BSHIFT_FLAGS_EN
            assign pc_s = carry_s[i-1];
`endif
        end

        if (i == PIPE_DEPTH - 1) begin : g_tail
            assign nr_s = out_ready;
        end else begin : g_mid
            assign nr_s = rdy_s[i+1];
        end

        bshift_stage #(
            .WIDTH       (WIDTH),
            .FIRST_LEVEL (FIRST),
            .LEVEL_CNT   (CNT)
        ) u_stage (
            .clk        (clk),
            .rst        (rst),
            .prev_valid (pv_s),
            .prev_data  (pd_s),
            .prev_amt   (pa_s),
            .prev_op    (po_s),
            .prev_err   (pe_s),
`ifdef BSHIFT_FLAGS_EN
            .prev_carry (pc_s),
            .carry_q    (carry_s[i]),
`endif
            .next_ready (nr_s),
            .load_ok    (rdy_s[i]),
            .valid_q    (valid_s[i]),
            .data_q     (data_s[i]),
            .amt_q      (amt_s[i]),
            .op_q       (op_s[i]),
            .err_q      (err_s[i])
        );
    end

    // in_ready is the head slice's load permission, rippled from out_ready.
    assign in_ready   = rdy_s[0];
    assign out_valid  = valid_s[PIPE_DEPTH-1];
    assign out_data   = data_s[PIPE_DEPTH-1];
    assign out_op_err = err_s[PIPE_DEPTH-1];
`ifdef BSHIFT_FLAGS_EN
    assign out_carry  = carry_s[PIPE_DEPTH-1];
    assign out_zero   = ~|data_s[PIPE_DEPTH-1];
`endif

endmodule

// File: doc/bshift_pipe.md
Name: bshift_pipe

Overview:
Parametrised, pipelined barrel shifter and rotator with valid/ready handshakes on input and output. It supports logical, arithmetic and rotate operations in both directions. It sits in the datapath wherever a multi-bit shift or rotate is needed at full clock rate. Each of the log2(WIDTH) mux levels is spread over PIPE_DEPTH register stages.

Parameters:
WIDTH, 32, data width; power of two, 4..64
PIPE_DEPTH, 2, number of register stages (= latency in cycles); 1..log2(WIDTH)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  input beat valid
in_ready  out  1  block can accept a beat this cycle
in_data  in  WIDTH  operand
in_amt  in  log2(WIDTH)  shift/rotate amount, 0..WIDTH-1
in_op  in  3  operation code (see Behaviour)
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_data  out  WIDTH  result
out_op_err  out  1  beat carried an undefined opcode

Behaviour:
- Clock and reset: one clock. rst is asynchronous and active-high.
- Reset values:
  - every stage valid bit = 0, so out_valid = 0
  - out_data = 0, out_op_err = 0
  - in_ready = 1 once rst deasserts
- Reset mid-operation: all in-flight beats are discarded, with no partial output.
- Opcodes (in_op):
  - 000 PASS
  - 001 SLL: zero fill from LSB
  - 010 SRL: zero fill from MSB
  - 011 SRA: MSB (sign) fill
  - 100 ROL
  - 101 ROR
  - 110 and 111 are undefined: result = in_data unchanged, out_op_err = 1 with that beat.
- Amount 0 returns in_data for every opcode.
- Mux levels: level k shifts by 2^k when in_amt[k] = 1.
  - Levels are assigned to stages in order, ceil(log2(WIDTH)/PIPE_DEPTH) levels per stage; the last stage may hold fewer.
  - Each stage registers its partial result plus the remaining amount bits, opcode and valid.
- Handshake:
  - A beat is accepted when in_valid && in_ready.
  - A result is consumed when out_valid && out_ready.
  - Stage i advances when it is empty, or when stage i+1 advances or is empty.
  - The last stage advances when it is empty or out_ready = 1.
  - in_ready = stage 0 may load. It is combinational from out_ready through the stage-advance chain, with no registered skid.
- Latency: exactly PIPE_DEPTH cycles from acceptance to out_valid when there is no backpressure.
- Throughput: one beat per cycle with out_ready held at 1.
- Backpressure:
  - While out_valid && !out_ready, out_data, out_op_err and any FLAGS outputs stay stable.
  - Bubbles in earlier stages still collapse.
  - in_ready drops only when every stage is full.
- Simultaneous accept and consume on a full pipe: allowed, and the pipe stays full.
- Ordering: strictly FIFO. No beat is dropped or duplicated.
- Width rule: amount width = log2(WIDTH). Every amount is legal, so there is no overflow case.

Optional Feature:
BSHIFT_FLAGS_EN
- Defined:
  - adds output out_zero (1 = out_data all zero)
  - adds output out_carry, the last bit shifted out:
    - SLL: in_data[WIDTH-amt]
    - SRL and SRA: in_data[amt-1]
    - 0 when amt = 0, and for PASS, rotates and undefined opcodes
  - Both outputs are aligned with out_data and reset to 0.
- Undefined: both ports and their logic are absent, and the other ports are unchanged.

Decomposition:
- Package bshift_pkg:
  - opcode enum bshift_op_e (OP_PASS, OP_SLL, OP_SRL, OP_SRA, OP_ROL, OP_ROR)
  - constant BSHIFT_OP_W = 3
  - function bshift_level, which applies one 2^k level for a given op
- Sub-module bshift_stage:
  - parameters WIDTH, first level index, level count
  - holds one register slice with valid, the advance logic and its mux levels
  - bshift_pipe instantiates PIPE_DEPTH copies and chains them

Test Plan:
- WIDTH=8, PIPE_DEPTH=2; SLL 0x81 amt 1, SRL 0x81 amt 1, SRA 0x81 amt 1, ROL 0x81 amt 1, ROR 0x81 amt 1, out_ready=1 -> 0x02, 0x40, 0xC0, 0x03, 0xC0, each exactly 2 cycles after acceptance, one result per cycle.
- All ops with amt 0 on 0xA5 -> 0xA5. SRA 0x80 amt 7 -> 0xFF. ROR 0x01 amt 7 -> 0x02.
- Backpressure: 5 back-to-back beats, out_ready=0 for 4 cycles -> in_ready falls after 2 accepts, out_data stable, then all 5 results emitted in order with none lost.
- op 110, data 0x3C, amt 3 -> out_data 0x3C, out_op_err=1; the next legal beat has out_op_err=0.
- Assert rst with 2 beats in flight, asynchronously mid-cycle -> out_valid=0 immediately; after release, no stale result appears and a new beat completes with 2-cycle latency.
- With BSHIFT_FLAGS_EN: SLL 0x80 amt 1 -> out_data 0x00, out_zero=1, out_carry=1. SRL 0x01 amt 2 -> out_data 0x00, out_zero=1, out_carry=0.
